// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wr_en,
  input  logic [2:0]        ls_rw_type,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [2:0]        mem_rw_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  // Handshake: a request transfers on a rising edge where both req_valid and
  // req_ready are high; ready is only offered in IDLE and never while rst is high.

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);
  localparam logic [2:0] RW_WORD  = 3'b010;

  state_t     state, state_next;
  logic [2:0] lat_cnt;
  logic       owner_ls;
  logic       wr_q;
  logic       grant_if, grant_ls;
  logic       accept, last_beat;

`ifdef MEM_ARB_RR_EN
  logic last_ls;

  always_ff @(posedge clk) begin
    if (rst) last_ls <= 1'b0;
    else if (accept) last_ls <= grant_ls;
  end

  // On a tie the port that was not granted last wins.
  always_comb begin
    grant_ls = ls_req_valid && !(if_req_valid && last_ls);
    grant_if = if_req_valid && !(ls_req_valid && !last_ls);
  end
`else
  always_comb begin
    grant_ls = ls_req_valid;
    grant_if = if_req_valid && !ls_req_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    accept       = 1'b0;
    last_beat    = 1'b0;
    mem_en       = 1'b0;
    mem_wr_en    = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if_req_ready = grant_if && !rst;
        ls_req_ready = grant_ls && !rst;
        accept       = grant_if || grant_ls;
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        busy      = 1'b1;
        // Write strobe only on the first command cycle so a store writes once.
        mem_wr_en = wr_q && (lat_cnt == LAT_INIT);
        last_beat = (lat_cnt == 3'd0);
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_ls      <= 1'b0;
      wr_q          <= 1'b0;
      lat_cnt       <= 3'd0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_rw_type   <= 3'd0;
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if_rdata      <= '0;
      ls_rdata      <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if (accept) begin
        owner_ls <= grant_ls;
        lat_cnt  <= LAT_INIT;
        if (grant_ls) begin
          mem_addr    <= ls_addr;
          mem_wdata   <= ls_wdata;
          mem_rw_type <= ls_rw_type;
          wr_q        <= ls_wr_en;
        end else begin
          mem_addr    <= if_addr;
          mem_wdata   <= '0;
          mem_rw_type <= RW_WORD;
          wr_q        <= 1'b0;
        end
      end
      if (state == ACCESS) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (last_beat) begin
          if (owner_ls) begin
            ls_resp_valid <= 1'b1;
            ls_rdata      <= wr_q ? '0 : mem_rdata;
          end else begin
            if_resp_valid <= 1'b1;
            if_rdata      <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-addressed memory model, vector table, scoreboard
// queues per port, plus reset, contention, back-to-back and MEM_LAT=1 sequences.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_init = 1'b1;
  logic              if_req_valid = 1'b0, if_req_ready, if_resp_valid;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req_valid = 1'b0, ls_req_ready, ls_resp_valid, ls_wr_en = 1'b0;
  logic [2:0]        ls_rw_type = 3'd0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0, ls_rdata;
  logic              mem_en, mem_wr_en, busy;
  logic [2:0]        mem_rw_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  // Second instance with single-cycle latency.
  logic              b_if_req_valid = 1'b0, b_if_req_ready, b_if_resp_valid;
  logic [ADDR_W-1:0] b_if_addr = '0;
  logic [DATA_W-1:0] b_if_rdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
  logic              b_ls_req_ready, b_ls_resp_valid, b_mem_en, b_mem_wr_en, b_busy;
  logic [2:0]        b_mem_rw_type;
  logic [ADDR_W-1:0] b_mem_addr;

  int cyc = 0, checks = 0, errors = 0, wr_cnt = 0;
  logic [7:0]        mem_b [0:1023];
  logic [DATA_W-1:0] if_exp_q[$];
  logic [DATA_W-1:0] ls_exp_q[$];

  typedef struct {
    bit          ls;
    bit          wr;
    logic [2:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [10];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_wr_en(ls_wr_en),
    .ls_rw_type(ls_rw_type), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rw_type(mem_rw_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_addr(b_if_addr),
    .if_resp_valid(b_if_resp_valid), .if_rdata(b_if_rdata),
    .ls_req_valid(1'b0), .ls_req_ready(b_ls_req_ready), .ls_wr_en(1'b0),
    .ls_rw_type(3'd0), .ls_addr(32'd0), .ls_wdata(32'd0),
    .ls_resp_valid(b_ls_resp_valid), .ls_rdata(b_ls_rdata),
    .mem_en(b_mem_en), .mem_wr_en(b_mem_wr_en), .mem_rw_type(b_mem_rw_type),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  assign b_mem_rdata = b_mem_addr ^ 32'h5A5A5A5A;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [9:0]  ra;
  logic [31:0] rword;
  always_comb begin
    ra    = mem_addr[9:0];
    rword = {mem_b[ra + 10'd3], mem_b[ra + 10'd2], mem_b[ra + 10'd1], mem_b[ra]};
    case (mem_rw_type[1:0])
      2'b00:   mem_rdata = mem_rw_type[2] ? {24'h0, rword[7:0]} : {{24{rword[7]}}, rword[7:0]};
      2'b01:   mem_rdata = mem_rw_type[2] ? {16'h0, rword[15:0]} : {{16{rword[15]}}, rword[15:0]};
      default: mem_rdata = rword;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= 8'h00;
      mem_b[0]     <= 8'h13;
      mem_b[1]     <= 8'h04;
      mem_b[10'h100] <= 8'h34;
      mem_b[10'h101] <= 8'h12;
      mem_b[10'h103] <= 8'h80;
    end else if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      mem_b[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_rw_type[1:0] != 2'b00) mem_b[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_rw_type[1]) begin
        mem_b[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem_b[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_resp_valid) begin
      if (if_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_resp unexpected pulse actual=1 expected=0 rdata=%h", if_rdata);
      end else check("if_rdata", if_rdata, if_exp_q.pop_front());
    end
    if (ls_resp_valid) begin
      if (ls_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ls_resp unexpected pulse actual=1 expected=0 rdata=%h", ls_rdata);
      end else check("ls_rdata", ls_rdata, ls_exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_ready(input bit ls, output bit got);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ls ? ls_req_ready : if_req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("accept", 32'(got), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    int wr0;
    @(negedge clk);
    if (v.ls) begin
      ls_req_valid = 1'b1; ls_wr_en = v.wr; ls_rw_type = v.rw;
      ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = v.addr;
    end
    #1;
    wait_ready(v.ls, got);
    if (v.ls) ls_exp_q.push_back(v.exp);
    else      if_exp_q.push_back(v.exp);
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    for (int k = 1; k <= MEM_LAT; k++) begin
      if (k > 1) @(negedge clk);
      check("mem_en_access", 32'(mem_en), 32'd1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_rw_type", 32'(mem_rw_type), v.ls ? 32'(v.rw) : 32'd2);
      if (v.ls && v.wr) check("mem_wdata", mem_wdata, v.wdata);
    end
    @(negedge clk);
    check("resp_valid", v.ls ? 32'(ls_resp_valid) : 32'(if_resp_valid), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("mem_en_after", 32'(mem_en), 32'd0);
    if (v.ls && v.wr) check("store_write_count", 32'(wr_cnt - wr0), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit got;
    int t0, t1, n, wr0;
    bit saw_if;

    vecs[0] = '{0, 0, 3'b010, 32'h80000000, 32'h0,        32'h00000413};
    vecs[1] = '{1, 1, 3'b000, 32'h80000101, 32'h000000AB, 32'h00000000};
    vecs[2] = '{1, 0, 3'b100, 32'h80000101, 32'h0,        32'h000000AB};
    vecs[3] = '{1, 0, 3'b000, 32'h80000103, 32'h0,        32'hFFFFFF80};
    vecs[4] = '{1, 1, 3'b001, 32'h80000104, 32'h0000BEEF, 32'h00000000};
    vecs[5] = '{1, 0, 3'b001, 32'h80000104, 32'h0,        32'hFFFFBEEF};
    vecs[6] = '{1, 0, 3'b101, 32'h80000104, 32'h0,        32'h0000BEEF};
    vecs[7] = '{1, 1, 3'b010, 32'h80000108, 32'hCAFEF00D, 32'h00000000};
    vecs[8] = '{0, 0, 3'b010, 32'h80000108, 32'h0,        32'hCAFEF00D};
    vecs[9] = '{1, 0, 3'b010, 32'h80000100, 32'h0,        32'h8000AB34};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_init = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_if_resp", 32'(if_resp_valid), 32'd0);
    check("rst_ls_resp", 32'(ls_resp_valid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_rw_type", 32'(mem_rw_type), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-to-back loads: second accept lands on the first response cycle.
    @(negedge clk);
    ls_req_valid = 1'b1; ls_wr_en = 1'b0; ls_rw_type = 3'b010; ls_addr = 32'h80000100;
    #1;
    wait_ready(1'b1, got);
    t0 = cyc;
    ls_exp_q.push_back(32'h8000AB34);
    @(posedge clk);
    @(negedge clk);
    ls_addr = 32'h80000000;
    #1;
    wait_ready(1'b1, got);
    t1 = cyc;
    check("b2b_resp_with_ready", 32'(ls_resp_valid), 32'd1);
    check("b2b_spacing", 32'(t1 - t0), 32'(MEM_LAT + 1));
    ls_exp_q.push_back(32'h00000413);
    @(posedge clk);
    @(negedge clk);
    ls_req_valid = 1'b0;
    repeat (MEM_LAT + 2) @(negedge clk);

    // Reset in the second command cycle of a store.
    @(negedge clk);
    ls_req_valid = 1'b1; ls_wr_en = 1'b1; ls_rw_type = 3'b010;
    ls_addr = 32'h8000010C; ls_wdata = 32'h11223344;
    #1;
    wait_ready(1'b1, got);
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    ls_req_valid = 1'b0;
    check("midrst_wr_en_first", 32'(mem_wr_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ls_resp", 32'(ls_resp_valid), 32'd0);
    check("midrst_ls_rdata", ls_rdata, 32'd0);
    check("midrst_if_rdata", if_rdata, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_write_count", 32'(wr_cnt - wr0), 32'd1);
    check("midrst_mem_word", {mem_b[271], mem_b[270], mem_b[269], mem_b[268]}, 32'h11223344);

    // Both ports continuously requesting, starting from the reset pointer.
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 32'h80000000;
    ls_req_valid = 1'b1; ls_wr_en = 1'b0; ls_rw_type = 3'b010; ls_addr = 32'h80000100;
    n = 0;
    saw_if = 1'b0;
    for (int k = 0; k < 100 && n < 6; k++) begin
      #1;
      if (if_req_ready) saw_if = 1'b1;
      if (if_req_ready || ls_req_ready) begin
        check("grant_one_hot", 32'(if_req_ready & ls_req_ready), 32'd0);
        check("grant_ls", 32'(ls_req_ready), RR ? 32'((n % 2) == 0) : 32'd1);
        if (ls_req_ready) ls_exp_q.push_back(32'h8000AB34);
        else              if_exp_q.push_back(32'h00000413);
        n++;
      end
      if (n < 6) @(negedge clk);
    end
    check("grant_count", 32'(n), 32'd6);
    @(posedge clk);
    @(negedge clk);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    check("if_ever_ready", 32'(saw_if), RR ? 32'd1 : 32'd0);
    repeat (MEM_LAT + 3) @(negedge clk);

    // Single-cycle latency instance.
    @(negedge clk);
    b_if_req_valid = 1'b1; b_if_addr = 32'h80000040;
    #1;
    check("l1_ready_t", 32'(b_if_req_ready), 32'd1);
    check("l1_busy_t", 32'(b_busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    b_if_req_valid = 1'b0;
    check("l1_busy_t1", 32'(b_busy), 32'd1);
    check("l1_mem_en_t1", 32'(b_mem_en), 32'd1);
    check("l1_resp_t1", 32'(b_if_resp_valid), 32'd0);
    @(negedge clk);
    check("l1_resp_t2", 32'(b_if_resp_valid), 32'd1);
    check("l1_rdata_t2", b_if_rdata, 32'hDA5A5A1A);
    check("l1_busy_t2", 32'(b_busy), 32'd0);
    check("l1_ls_resp", 32'(b_ls_resp_valid), 32'd0);
    @(negedge clk);
    check("l1_resp_t3", 32'(b_if_resp_valid), 32'd0);

    repeat (3) @(negedge clk);
    check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
    check("ls_queue_drained", 32'(ls_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares the single data/instruction memory port between the instruction-fetch unit (IF) and the load/store unit (LS). It accepts one request at a time from either requester over a valid/ready handshake and registers the command. It then drives it to the memory for a fixed number of cycles and returns a one-cycle response pulse with registered read data. It sits between the core pipeline and the DDR memory model, replacing the dual-ported fetch/data access with a single arbitrated port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles the command is held on the memory port before read data is sampled; legal 1..7

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF request pending
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  ADDR_W  IF fetch address (always word read)
- if_resp_valid  out  1  one-cycle IF completion pulse
- if_rdata  out  DATA_W  IF read data, valid with if_resp_valid
- ls_req_valid  in  1  LS request pending
- ls_req_ready  out  1  LS request accepted this cycle
- ls_wr_en  in  1  1 = store, 0 = load
- ls_rw_type  in  3  size/sign code: [1:0] 00 byte, 01 half, 1x word; [2] 1 = zero-extend
- ls_addr  in  ADDR_W  LS address
- ls_wdata  in  DATA_W  store data (low-aligned)
- ls_resp_valid  out  1  one-cycle LS completion pulse (loads and stores)
- ls_rdata  out  DATA_W  load data; 0 on store completion
- mem_en  out  1  memory command active
- mem_wr_en  out  1  memory write strobe
- mem_rw_type  out  3  forwarded size/sign code; 3'b010 for IF
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr)
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- FSM: IDLE, ACCESS. Reset → IDLE.
- IDLE: if any req_valid, pick a winner, assert its req_ready combinationally, capture owner, addr, wdata, wr_en, rw_type, and load lat_cnt = MEM_LAT-1 → ACCESS. The loser's ready stays 0.
- ACCESS: mem_en = 1. mem_* are driven from the captured registers. lat_cnt decrements each cycle. At lat_cnt == 0, mem_rdata is registered into the owner's rdata, the owner's resp_valid is set for the next cycle, and the FSM returns to IDLE.
- mem_wr_en = 1 only in the first ACCESS cycle of a store. Exactly one write per store.
- Responses have no backpressure. The pulse is exactly one cycle wide. rdata holds its value until the next response to the same port.
- The non-owner's resp_valid stays 0. IF never writes.
- Outputs when idle: mem_en = 0, mem_wr_en = 0, and mem_addr/mem_wdata/mem_rw_type hold their last values.
- Reset values: all *_ready, *_resp_valid, mem_en, mem_wr_en, and busy are 0. if_rdata, ls_rdata, mem_addr, and mem_wdata are 0. mem_rw_type = 0. Round-robin pointer = IF-last (LS wins the first tie).
- Reset mid-transaction: the transaction is dropped, no response is issued, and the next cycle is IDLE with all outputs at reset values.

## Timing
- Accept in cycle T. mem_en is high in T+1..T+MEM_LAT. mem_rdata is sampled at the end of T+MEM_LAT. resp_valid is high in T+MEM_LAT+1.
- FSM is IDLE in T+MEM_LAT+1, so a new accept may coincide with the response pulse. Peak throughput is one transaction per MEM_LAT+1 cycles.
- req_ready depends only on state and the valid inputs (no path from mem_rdata).
- Requesters hold valid and payload stable until ready.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the port not granted last wins.
  - The pointer updates on every accept.
  - Neither port waits more than one foreign transaction.
- Not defined: fixed priority, LS over IF. IF is granted only when ls_req_valid = 0 in IDLE. The pointer logic is absent.

## Test plan
- Reset with MEM_LAT = 2, then IF read of 0x80000000 where memory holds 0x00000413 → if_req_ready in T, mem_en in T+1..T+2, if_resp_valid and if_rdata = 0x00000413 in T+3.
- LS store byte 0xAB at 0x80000101 (rw_type 000), then LS load (rw_type 100) → mem_wr_en high for exactly one cycle; the load returns ls_rdata = 0x000000AB; the store response has ls_rdata = 0.
- IF and LS both continuously valid for 6 transactions → with MEM_ARB_RR_EN, grants alternate LS, IF, LS, IF, …; without it, all 6 grants go to LS and if_req_ready stays 0.
- Back-to-back LS loads → the second req_ready coincides with the first ls_resp_valid, giving a spacing of MEM_LAT+1 = 3 cycles.
- rst asserted in the second ACCESS cycle of a store → no resp_valid, mem_en = 0 the next cycle, and memory is written at most once.
- MEM_LAT = 1 → accept in T, response in T+2, busy high only in T+1.
